ff_table_loader: RTL

FF_TABLE_LOADER -- requirements
Module: ff_table_loader

---
 rtl/ff_table_loader_pkg.sv | 25 ++
 rtl/ff_table_loader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ff_table_loader_pkg.sv
// Shared definitions for the match-table loader: command encodings,
// FSM state codes, default geometry and the no-match fill pattern.
package ff_table_loader_pkg;

  localparam int DEF_AWIDTH       = 13;
  localparam int DEF_DWIDTH       = 64;
  localparam int DEF_DRAIN_CYCLES = 3;

  // Command opcodes carried on cmd_op
  localparam logic [1:0] OP_STAGE_LO = 2'd0;
  localparam logic [1:0] OP_WRITE    = 2'd1;
  localparam logic [1:0] OP_FILL     = 2'd2;
  localparam logic [1:0] OP_RSVD     = 2'd3;

  // Loader FSM states, kept as plain constants for legacy tool flows
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DRAIN = 2'd1;
  localparam state_t ST_WRITE = 2'd2;
  localparam state_t ST_FILL  = 2'd3;

  // Entry value that never matches; used to wipe the whole table
  localparam logic [63:0] FILL_NOMATCH = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/ff_table_loader.sv
// Match-table loader: accepts staged commands, pauses upstream, waits for
// the filter pipeline to go quiet, then performs a single entry write or a
// full-table fill. Every write-side output comes straight from a register.
module ff_table_loader
  import ff_table_loader_pkg::*;
#(
  parameter int AWIDTH       = DEF_AWIDTH,
  parameter int DWIDTH       = DEF_DWIDTH,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [31:0]       cmd_data,
  input  logic              mon_valid,
  input  logic              mon_sop,
  input  logic              mon_eop,
  output logic              pause,
  output logic              wr_en,
  output logic [AWIDTH-1:0] wr_addr,
  output logic [DWIDTH-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int QW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_t              state_q, state_d;
  logic [31:0]         lo_q, lo_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   data_q, data_d;
  logic [1:0]          op_q, op_d;
  logic                inPkt_q, inPkt_d;
  logic [QW-1:0]       quiet_q, quiet_d;
  logic [AWIDTH-1:0]   fill_q, fill_d;
  logic                wrEn_q, wrEn_d;
  logic [AWIDTH-1:0]   wrAddr_q, wrAddr_d;
  logic [DWIDTH-1:0]   wrData_q, wrData_d;
  logic                pause_q, pause_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                quietCycle;

  assign cmd_ready  = (state_q == ST_IDLE);
  assign quietCycle = !mon_valid && !inPkt_q;

  assign pause   = pause_q;
  assign wr_en   = wrEn_q;
  assign wr_addr = wrAddr_q;
  assign wr_data = wrData_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

  // Next-state logic: command decode, packet tracking, drain timing, write sequencing
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    addr_d   = addr_q;
    data_d   = data_q;
    op_d     = op_q;
    quiet_d  = quiet_q;
    fill_d   = fill_q;
    wrEn_d   = 1'b0;
    wrAddr_d = wrAddr_q;
    wrData_d = wrData_q;
    done_d   = 1'b0;

    // A packet opens on a non-final SOP and closes on any EOP beat
    inPkt_d = inPkt_q;
    if (mon_valid && mon_eop) begin
      inPkt_d = 1'b0;
    end else if (mon_valid && mon_sop) begin
      inPkt_d = 1'b1;
    end

    // Any live traffic while the table is being written is flagged, sticky
    err_d = err_q | (wrEn_q & mon_valid);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_STAGE_LO: begin
              lo_d = cmd_data;
            end
            OP_WRITE, OP_FILL: begin
              addr_d  = cmd_addr;
              data_d  = DWIDTH'({cmd_data, lo_q});
              op_d    = cmd_op;
              quiet_d = '0;
              fill_d  = '0;
              state_d = ST_DRAIN;
            end
            default: begin
            end
          endcase
        end
      end

      ST_DRAIN: begin
        if (quietCycle) begin
          quiet_d = quiet_q + QW'(1);
          if (quiet_q == QW'(DRAIN_CYCLES - 1)) begin
            state_d = (op_q == OP_FILL) ? ST_FILL : ST_WRITE;
          end
        end else begin
          quiet_d = '0;
        end
      end

      ST_WRITE: begin
        if (wrEn_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wrEn_d   = 1'b1;
          wrAddr_d = addr_q;
          wrData_d = data_q;
        end
      end

      ST_FILL: begin
        if (wrEn_q && (wrAddr_q == '1)) begin
          done_d  = 1'b1;
          fill_d  = '0;
          state_d = ST_IDLE;
        end else begin
          wrEn_d   = 1'b1;
          wrAddr_d = fill_q;
          wrData_d = data_q;
          fill_d   = fill_q + AWIDTH'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d  = (state_d != ST_IDLE);
    pause_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lo_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      op_q     <= OP_STAGE_LO;
      inPkt_q  <= 1'b0;
      quiet_q  <= '0;
      fill_q   <= '0;
      wrEn_q   <= 1'b0;
      wrAddr_q <= '0;
      wrData_q <= '0;
      pause_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      op_q     <= op_d;
      inPkt_q  <= inPkt_d;
      quiet_q  <= quiet_d;
      fill_q   <= fill_d;
      wrEn_q   <= wrEn_d;
      wrAddr_q <= wrAddr_d;
      wrData_q <= wrData_d;
      pause_q  <= pause_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule
